// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - shared types, digit indices and segment encodings for the display scanner
package bcd_display_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t DIG_LS_MIN  = 2'd0;
    localparam digit_idx_t DIG_MS_MIN  = 2'd1;
    localparam digit_idx_t DIG_LS_HOUR = 2'd2;
    localparam digit_idx_t DIG_MS_HOUR = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low {g,f,e,d,c,b,a}; codes 10..15 are not BCD and show a dash
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
    };

    typedef struct packed {
        logic [3:0] ms_hour;
        logic [3:0] ls_hour;
        logic [3:0] ms_min;
        logic [3:0] ls_min;
    } bcd_time_t;

endpackage

// File: rtl/bcd_display_scan_if.sv
// rtl/bcd_display_scan_if.sv - BCD time in, multiplexed 7-segment drive out
interface bcd_display_scan_if;
    logic [3:0] ms_hour;
    logic [3:0] ls_hour;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;

    // Clock stage / test driver side
    modport master (
        output ms_hour, ls_hour, ms_min, ls_min,
        input  an_n, seg_n, dp_n
    );

    // Display scanner side
    modport slave (
        input  ms_hour, ls_hour, ms_min, ls_min,
        output an_n, seg_n, dp_n
    );
endinterface

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD to active-low 7-segment decoder
module bcd_to_7seg
    import bcd_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    // Table lookup; non-BCD codes already map to a dash in the table
    always_comb begin
        seg_n = SEG_TABLE[bcd];
    end

endmodule

// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - 4-digit multiplexed display scanner with per-frame snapshot; optional LEAD_ZERO_BLANK_EN
module bcd_display_scan
    import bcd_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 50000000,
    parameter int COLON_BLINK = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_display_scan_if.slave disp
);

    localparam int DIV_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [DIV_W-1:0]   div_cnt_q,     div_cnt_d;
    digit_idx_t         digit_sel_q,   digit_sel_d;
    logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    bcd_time_t          snap_q,        snap_d;
    logic [3:0]         an_n_q,        an_n_d;
    logic [6:0]         seg_n_q,       seg_n_d;
    logic               dp_n_q,        dp_n_d;

    logic               div_wrap;
    logic [3:0]         cur_digit;
    logic [6:0]         dec_seg_n;

    bcd_to_7seg u_dec (
        .bcd   (cur_digit),
        .seg_n (dec_seg_n)
    );

    // Scan/blink counters, frame snapshot and next output values
    always_comb begin
        div_wrap      = (div_cnt_q == DIV_LAST);
        div_cnt_d     = div_wrap ? '0 : div_cnt_q + 1'b1;
        digit_sel_d   = div_wrap ? digit_sel_q + 1'b1 : digit_sel_q;

        blink_cnt_d   = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = (blink_cnt_q == BLINK_LAST) ? ~blink_phase_q : blink_phase_q;

        // Capture on the last cycle of the last digit so the next frame is coherent
        snap_d = snap_q;
        if (div_wrap && (digit_sel_q == DIG_MS_HOUR)) begin
            snap_d.ms_hour = disp.ms_hour;
            snap_d.ls_hour = disp.ls_hour;
            snap_d.ms_min  = disp.ms_min;
            snap_d.ls_min  = disp.ls_min;
        end

        unique case (digit_sel_q)
            DIG_LS_MIN:  cur_digit = snap_q.ls_min;
            DIG_MS_MIN:  cur_digit = snap_q.ms_min;
            DIG_LS_HOUR: cur_digit = snap_q.ls_hour;
            default:     cur_digit = snap_q.ms_hour;
        endcase

        an_n_d  = ~(4'b0001 << digit_sel_q);
        seg_n_d = dec_seg_n;
        dp_n_d  = ~((digit_sel_q == DIG_LS_HOUR) && (blink_phase_q || (COLON_BLINK == 0)));

`ifdef LEAD_ZERO_BLANK_EN
        // A leading zero in the tens-of-hours slot turns that digit fully off
        if ((digit_sel_q == DIG_MS_HOUR) && (snap_q.ms_hour == 4'd0)) begin
            an_n_d  = 4'b1111;
            seg_n_d = SEG_BLANK;
        end
`endif
    end

    // State and registered outputs; reset blanks the display immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            digit_sel_q   <= DIG_LS_MIN;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            snap_q        <= '0;
            an_n_q        <= 4'b1111;
            seg_n_q       <= SEG_BLANK;
            dp_n_q        <= 1'b1;
        end else begin
            div_cnt_q     <= div_cnt_d;
            digit_sel_q   <= digit_sel_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            snap_q        <= snap_d;
            an_n_q        <= an_n_d;
            seg_n_q       <= seg_n_d;
            dp_n_q        <= dp_n_d;
        end
    end

    assign disp.an_n  = an_n_q;
    assign disp.seg_n = seg_n_q;
    assign disp.dp_n  = dp_n_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb/tb_bcd_display_scan.sv - self-checking bench for bcd_display_scan
module tb_bcd_display_scan;

    localparam int R = 4;
    localparam int B = 32;

    logic clk;
    logic rst_n;

    bcd_display_scan_if bus ();
    bcd_display_scan_if bus_nb ();

    assign bus_nb.ms_hour = bus.ms_hour;
    assign bus_nb.ls_hour = bus.ls_hour;
    assign bus_nb.ms_min  = bus.ms_min;
    assign bus_nb.ls_min  = bus.ls_min;

    bcd_display_scan #(.REFRESH_DIV(R), .BLINK_DIV(B), .COLON_BLINK(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .disp  (bus)
    );

    bcd_display_scan #(.REFRESH_DIV(R), .BLINK_DIV(B), .COLON_BLINK(0)) dut_nb (
        .clk   (clk),
        .rst_n (rst_n),
        .disp  (bus_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got an/seg/dp=%h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Reference model: k = rising edges since reset release; the output after
    // edge k shows slot ((k-1)/R)%4 of the frame snapshot, and the snapshot is
    // refreshed from the inputs at every edge where k is a multiple of 4R.
    int         k;
    logic [3:0] snap [4];
    logic [11:0] exp_c, exp_nb;

    always @(posedge clk) begin
        int d;
        int ph;
        logic [3:0] an;
        logic [6:0] sg;
        if (!rst_n) begin
            k = 0;
            for (int i = 0; i < 4; i++) snap[i] = 4'd0;
            exp_c  = {4'b1111, 7'h7F, 1'b1};
            exp_nb = exp_c;
        end else begin
            k++;
            d  = ((k - 1) / R) % 4;
            ph = ((k - 1) / B) % 2;
            an = 4'b1111;
            an[d] = 1'b0;
            sg = seg_of(snap[d]);
`ifdef LEAD_ZERO_BLANK_EN
            if (d == 3 && snap[3] == 4'd0) begin
                an = 4'b1111;
                sg = 7'h7F;
            end
`endif
            exp_c  = {an, sg, !(d == 2 && ph == 1)};
            exp_nb = {an, sg, !(d == 2)};
            if (k % (4 * R) == 0) begin
                snap[0] = bus.ls_min;
                snap[1] = bus.ms_min;
                snap[2] = bus.ls_hour;
                snap[3] = bus.ms_hour;
            end
        end
        #1;
        check("scan_blink", {bus.an_n, bus.seg_n, bus.dp_n}, exp_c);
        check("scan_steady", {bus_nb.an_n, bus_nb.seg_n, bus_nb.dp_n}, exp_nb);
    end

    // Returns just after the edge whose output shows slot d
    task automatic wait_slot(input int d);
        bit found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(posedge clk);
            #2;
            if (rst_n && k > 0 && ((k - 1) / R) % 4 == d) found = 1;
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_slot_%0d: slot not reached within 64 cycles", d);
        end
    endtask

    task automatic set_time(input logic [3:0] mh, input logic [3:0] lh,
                            input logic [3:0] mm, input logic [3:0] lm);
        @(negedge clk);
        bus.ms_hour = mh;
        bus.ls_hour = lh;
        bus.ms_min  = mm;
        bus.ls_min  = lm;
    endtask

    typedef struct {
        logic [3:0] val;
        logic [6:0] seg;
    } dec_vec_t;

    dec_vec_t tbl [16];

    initial begin
        n_vec = 0;
        n_err = 0;
        tbl[0]  = '{4'd0,  7'h40}; tbl[1]  = '{4'd1,  7'h79};
        tbl[2]  = '{4'd2,  7'h24}; tbl[3]  = '{4'd3,  7'h30};
        tbl[4]  = '{4'd4,  7'h19}; tbl[5]  = '{4'd5,  7'h12};
        tbl[6]  = '{4'd6,  7'h02}; tbl[7]  = '{4'd7,  7'h78};
        tbl[8]  = '{4'd8,  7'h00}; tbl[9]  = '{4'd9,  7'h10};
        tbl[10] = '{4'd10, 7'h3F}; tbl[11] = '{4'd11, 7'h3F};
        tbl[12] = '{4'd12, 7'h3F}; tbl[13] = '{4'd13, 7'h3F};
        tbl[14] = '{4'd14, 7'h3F}; tbl[15] = '{4'd15, 7'h3F};

        rst_n = 1'b0;
        bus.ms_hour = 4'd1;
        bus.ls_hour = 4'd2;
        bus.ms_min  = 4'd3;
        bus.ls_min  = 4'd4;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * 4 * R) @(negedge clk);

        // Mid-frame change of ls_min is held off until the next snapshot
        wait_slot(1);
        set_time(4'd1, 4'd2, 4'd3, 4'd5);
        repeat (2 * 4 * R) @(negedge clk);

        // Non-BCD code in the ms_min slot
        set_time(4'd1, 4'd2, 4'hC, 4'd5);
        repeat (2 * 4 * R) @(negedge clk);

        // Decoder table, checked on the ls_min and ls_hour slots
        for (int i = 0; i < 16; i++) begin
            set_time(tbl[i].val, tbl[i].val, tbl[i].val, tbl[i].val);
            repeat (2 * 4 * R) @(negedge clk);
            wait_slot(0);
            check("dec_ls_min", {5'd0, bus.seg_n}, {5'd0, tbl[i].seg});
            wait_slot(2);
            check("dec_ls_hour", {5'd0, bus_nb.seg_n}, {5'd0, tbl[i].seg});
        end

        // Leading-zero hour then a two-digit hour; long enough to cover both colon phases
        set_time(4'd0, 4'd9, 4'd5, 4'd9);
        repeat (4 * 4 * R) @(negedge clk);
        set_time(4'd1, 4'd0, 4'd0, 4'd0);
        repeat (4 * 4 * R) @(negedge clk);

        // One-cycle reset in the ls_hour slot blanks outputs without a clock edge
        wait_slot(2);
        rst_n = 1'b0;
        #1;
        check("async_rst", {bus.an_n, bus.seg_n, bus.dp_n}, {4'b1111, 7'h7F, 1'b1});
        check("async_rst_nb", {bus_nb.an_n, bus_nb.seg_n, bus_nb.dp_n}, {4'b1111, 7'h7F, 1'b1});
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * 4 * R) @(negedge clk);

        // Randomized time values changing every cycle
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            bus.ms_hour = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            bus.ls_hour = 4'($urandom_range(0, 15));
            bus.ms_min  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
            bus.ls_min  = 4'($urandom_range(0, 9));
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
